// File: rtl/seven_seg_scan_driver_if.sv
// Display-request bus of the seven-segment scan driver.
// The master supplies value, strobe and mode; the slave returns status and scan outputs.
interface seven_seg_scan_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]  Value;
  logic              Load;
  logic              DecMode;
  logic              Busy;
  logic              Overflow;
  logic [7:0]        SegOut;
  logic [DIGITS-1:0] DigitEn;

  modport master (
    output Value, Load, DecMode,
    input  Busy, Overflow, SegOut, DigitEn
  );

  modport slave (
    input  Value, Load, DecMode,
    output Busy, Overflow, SegOut, DigitEn
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment driver: captures a binary value, shows it in hex or decimal
// (serial double-dabble), with leading-zero blanking, overflow dashes and digit scanning.
module seven_seg_scan_driver #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 1
) (
  input logic                    Clk,
  input logic                    Rst_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int NB     = (WIDTH < 4 * DIGITS) ? WIDTH : 4 * DIGITS;

  typedef logic [DIGITS-1:0][7:0] disp_t;

  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  disp_t             disp_q, disp_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] en_q, en_d;

  logic [BCD_W-1:0]  adj_s;
  logic              dec_ovf_s;
  logic              load_ok_s;

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'h3F;  4'h1: p = 8'h06;  4'h2: p = 8'h5B;  4'h3: p = 8'h4F;
      4'h4: p = 8'h66;  4'h5: p = 8'h6D;  4'h6: p = 8'h7D;  4'h7: p = 8'h07;
      4'h8: p = 8'h7F;  4'h9: p = 8'h6F;  4'hA: p = 8'h77;  4'hB: p = 8'h7C;
      4'hC: p = 8'h39;  4'hD: p = 8'h5E;  4'hE: p = 8'h79;  4'hF: p = 8'h71;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  function automatic logic [4*DIGITS-1:0] hex_nibs(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) r[b] = v[b];
    return r;
  endfunction

  function automatic logic hex_ovf(input logic [WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    for (int b = 4 * DIGITS; b < WIDTH; b++) r = r | v[b];
    return r;
  endfunction

  // Scanning from the top digit, zeros stay blank until the first non-zero nibble.
  function automatic disp_t build_disp(input logic [4*DIGITS-1:0] nibs, input logic ovf);
    disp_t r;
    logic  lead;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf) begin
        r[i] = 8'h40;
      end else begin
        lead = lead && (nibs[4*i +: 4] == 4'h0);
        if (BLANK_LZ != 0 && lead && i != 0) r[i] = 8'h00;
        else                                 r[i] = enc(nibs[4*i +: 4]);
      end
    end
    return r;
  endfunction

  // Next-state logic: scan timing, value capture and one double-dabble step per cycle.
  always_comb begin
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    lost_d    = lost_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    adj_s     = bcd_q;
    dec_ovf_s = 1'b0;
    load_ok_s = bus.Load && !busy_q;

    if (tick_q == TICK_W'(SCAN_DIV - 1)) begin
      tick_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
      else                             idx_d = idx_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    for (int n = 0; n <= DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) adj_s[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      else                         adj_s[4*n +: 4] = bcd_q[4*n +: 4];
    end

    if (load_ok_s && !bus.DecMode) begin
      ovf_d  = hex_ovf(bus.Value);
      disp_d = build_disp(hex_nibs(bus.Value), hex_ovf(bus.Value));
    end else if (load_ok_s) begin
      busy_d = 1'b1;
      sh_d   = bus.Value;
      bcd_d  = '0;
      lost_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      // A bit carried out of the extra top nibble also means the value cannot fit.
      bcd_d  = {adj_s[BCD_W-2:0], sh_q[WIDTH-1]};
      sh_d   = sh_q << 1;
      lost_d = lost_q | adj_s[BCD_W-1];
      cnt_d  = cnt_q + 1'b1;
      dec_ovf_s = lost_d || (bcd_d[BCD_W-1 -: 4] != 4'h0);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
        ovf_d  = dec_ovf_s;
        disp_d = build_disp(bcd_d[4*DIGITS-1:0], dec_ovf_s);
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end

    seg_d = 8'h00;
    for (int i = 0; i < DIGITS; i++) begin
      en_d[i] = (idx_d == IDX_W'(i));
      if (idx_d == IDX_W'(i)) seg_d = disp_d[i];
      else                    seg_d = seg_d;
    end
  end

  // State and registered outputs; reset blanks the display and aborts any conversion.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      sh_q   <= '0;
      bcd_q  <= '0;
      lost_q <= 1'b0;
      cnt_q  <= '0;
      disp_q <= '0;
      tick_q <= '0;
      idx_q  <= '0;
      seg_q  <= 8'h00;
      en_q   <= DIGITS'(1);
    end else begin
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      lost_q <= lost_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      tick_q <= tick_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      en_q   <= en_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Overflow = ovf_q;
  assign bus.SegOut   = seg_q;
  assign bus.DigitEn  = en_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 3-digit and a 2-digit instance, directed loads,
// expected digit patterns queued per instance and checked by scan monitors.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.WIDTH(8), .DIGITS(3)) ifa ();
  seven_seg_scan_driver_if #(.WIDTH(8), .DIGITS(2)) ifb ();

  seven_seg_scan_driver #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .Clk(clk), .Rst_n(rst_n), .bus(ifa)
  );
  seven_seg_scan_driver #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) u_b (
    .Clk(clk), .Rst_n(rst_n), .bus(ifb)
  );

  typedef struct { int idx; logic [7:0] seg; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int ma_idx, ma_tick, mb_idx, mb_tick;
  logic [7:0] old_a [3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent scan-position model: 4 cycles per digit, wrapping.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_idx <= 0; ma_tick <= 0; mb_idx <= 0; mb_tick <= 0;
    end else begin
      ma_tick <= (ma_tick == 3) ? 0 : ma_tick + 1;
      if (ma_tick == 3) ma_idx <= (ma_idx == 2) ? 0 : ma_idx + 1;
      mb_tick <= (mb_tick == 3) ? 0 : mb_tick + 1;
      if (mb_tick == 3) mb_idx <= (mb_idx == 1) ? 0 : mb_idx + 1;
    end
  end

  // Monitors: check the enable every cycle and pop queued patterns at each slot start.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("scanA", 32'(ifa.DigitEn), 32'(1) << ma_idx);
      if (ma_tick == 0 && qa.size() > 0 && qa[0].idx == ma_idx) begin
        e = qa.pop_front();
        check("segA", 32'(ifa.SegOut), 32'(e.seg));
      end
      check("scanB", 32'(ifb.DigitEn), 32'(1) << mb_idx);
      if (mb_tick == 0 && qb.size() > 0 && qb[0].idx == mb_idx) begin
        e = qb.pop_front();
        check("segB", 32'(ifb.SegOut), 32'(e.seg));
      end
    end
  end

  task automatic push_a(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    qa.push_back('{0, s0}); qa.push_back('{1, s1}); qa.push_back('{2, s2});
    old_a[0] = s0; old_a[1] = s1; old_a[2] = s2;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  task automatic load_a(input logic [7:0] v, input logic d);
    @(negedge clk);
    ifa.Value = v; ifa.DecMode = d; ifa.Load = 1'b1;
    @(negedge clk);
    ifa.Load = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v, input logic d);
    @(negedge clk);
    ifb.Value = v; ifb.DecMode = d; ifb.Load = 1'b1;
    @(negedge clk);
    ifb.Load = 1'b0;
  endtask

  // Counts busy negedges on A while checking the held display; optional late Load at cnt==3.
  task automatic busy_hold_a(input string nm, input bit inject);
    int cnt = 0;
    while (ifa.Busy && cnt < 40) begin
      check("holdA", 32'(ifa.SegOut), 32'(old_a[ma_idx]));
      if (inject && cnt == 3) begin
        ifa.Value = 8'd7; ifa.DecMode = 1'b1; ifa.Load = 1'b1;
      end else begin
        ifa.Load = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    ifa.Load = 1'b0;
    check(nm, 32'(cnt), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifa.Value = '0; ifa.Load = 1'b0; ifa.DecMode = 1'b0;
    ifb.Value = '0; ifb.Load = 1'b0; ifb.DecMode = 1'b0;
    repeat (3) @(negedge clk);
    // 1: reset state
    check("rstBusyA", 32'(ifa.Busy), 32'd0);
    check("rstOvfA",  32'(ifa.Overflow), 32'd0);
    check("rstEnA",   32'(ifa.DigitEn), 32'h1);
    check("rstSegA",  32'(ifa.SegOut), 32'h00);
    check("rstEnB",   32'(ifb.DigitEn), 32'h1);
    rst_n = 1'b1;
    push_a(8'h00, 8'h00, 8'h00);
    drain();

    // 2: hex 0x8C, Busy never rises
    load_a(8'h8C, 1'b0);
    push_a(8'h39, 8'h7F, 8'h00);
    check("hexOvfA", 32'(ifa.Overflow), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("hexBusyA", 32'(ifa.Busy), 32'd0);
      @(negedge clk);
    end
    drain();

    // 3: decimal 140, busy 8 cycles with old display held
    load_a(8'h8C, 1'b1);
    busy_hold_a("dec140Busy", 1'b0);
    check("dec140Ovf", 32'(ifa.Overflow), 32'd0);
    push_a(8'h3F, 8'h66, 8'h06);
    drain();

    // 4: second Load during conversion is ignored
    load_a(8'd255, 1'b1);
    busy_hold_a("dec255Busy", 1'b1);
    push_a(8'h6D, 8'h6D, 8'h5B);
    for (int i = 0; i < 12; i++) begin
      check("busyOnceA", 32'(ifa.Busy), 32'd0);
      @(negedge clk);
    end
    drain();

    // 5: 2-digit overflow then recovery
    load_b(8'd200, 1'b1);
    n = 0;
    while (ifb.Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("dec200BusyB", 32'(n), 32'd8);
    check("ovfSetB", 32'(ifb.Overflow), 32'd1);
    qb.push_back('{0, 8'h40}); qb.push_back('{1, 8'h40});
    drain();
    load_b(8'hFF, 1'b0);
    check("ovfClrB", 32'(ifb.Overflow), 32'd0);
    qb.push_back('{0, 8'h71}); qb.push_back('{1, 8'h71});
    drain();

    // 6: reset mid-conversion
    load_a(8'd99, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("midBusyA", 32'(ifa.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abortBusyA", 32'(ifa.Busy), 32'd0);
    check("abortOvfA",  32'(ifa.Overflow), 32'd0);
    check("abortEnA",   32'(ifa.DigitEn), 32'h1);
    check("abortSegA",  32'(ifa.SegOut), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    push_a(8'h00, 8'h00, 8'h00);
    drain();
    load_a(8'd0, 1'b1);
    busy_hold_a("dec0Busy", 1'b0);
    push_a(8'h3F, 8'h00, 8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
